// File: rtl/status_skip_unit_if.sv
// status_skip_unit_if
//   Bundles the controller/datapath signals of the status-register and
//   skip-condition block.
//   master : drives IR, flag load mask, source selects and the ARU/LGU
//            results; observes SR, enSKP and flagsChanged.
//   slave  : the status_skip_unit itself.
interface status_skip_unit_if #(
  parameter int W = 16
);
  logic [15:0]  inst;
  logic [3:0]   ldSR;
  logic         selSET_SR;
  logic         selARU_SR;
  logic         selLGU_SR;
  logic [W-1:0] aruResult;
  logic         aruCarry;
  logic         aruOverflow;
  logic [W-1:0] lguResult;
  logic [3:0]   SR;
  logic         enSKP;
  logic         flagsChanged;

  modport master (
    output inst, ldSR, selSET_SR, selARU_SR, selLGU_SR,
           aruResult, aruCarry, aruOverflow, lguResult,
    input  SR, enSKP, flagsChanged
  );

  modport slave (
    input  inst, ldSR, selSET_SR, selARU_SR, selLGU_SR,
           aruResult, aruCarry, aruOverflow, lguResult,
    output SR, enSKP, flagsChanged
  );
endinterface

// File: rtl/status_skip_unit.sv
// status_skip_unit
//   Holds the processor flags {Z,N,C,V}, reloads them under a per-flag mask
//   from the SET immediate, the ARU result or the LGU result (that priority),
//   and evaluates the SKP condition of the current IR against the registered
//   flags.
// Ports
//   clk, rst : system clock, synchronous active-high reset
//   bus      : status_skip_unit_if.slave
//              in : inst, ldSR, selSET_SR, selARU_SR, selLGU_SR,
//                   aruResult, aruCarry, aruOverflow, lguResult
//              out: SR (registered), enSKP (combinational),
//                   flagsChanged (registered pulse)
module status_skip_unit #(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  status_skip_unit_if.slave    bus
);

  logic [3:0] sr_p0;
  logic       chg_p0;
  logic [3:0] cand;
  logic [3:0] sr_next;

  // Per-bit merge: loaded flags take the candidate, the rest hold.
  function automatic logic [3:0] mask_load(input logic [3:0] cur,
                                           input logic [3:0] nxt,
                                           input logic [3:0] en);
    return (nxt & en) | (cur & ~en);
  endfunction

  // SKP decode: opcode F5, M = inst[7:4] selects tested flags, P = inst[3:0]
  // gives the required level. An empty mask is an unconditional skip.
  function automatic logic skip_eval(input logic [15:0] ir,
                                     input logic [3:0]  sr);
    logic [3:0] ok;
    ok = ~ir[7:4] | ~(sr ^ ir[3:0]);
    return (ir[15:8] == 8'hF5) && (&ok);
  endfunction

  // Candidate selection. Results are only looked at when their select is
  // active and some flag is actually loading, so an X on an idle source
  // never reaches the flops.
  always_comb begin
    cand = sr_p0;
    if (bus.ldSR != 4'b0000) begin
      if (bus.selSET_SR)
        cand = bus.inst[3:0];
      else if (bus.selARU_SR)
        cand = {(bus.aruResult == '0), bus.aruResult[W-1],
                bus.aruCarry, bus.aruOverflow};
      else if (bus.selLGU_SR)
        cand = {(bus.lguResult == '0), bus.lguResult[W-1], 2'b00};
    end
    sr_next = mask_load(sr_p0, cand, bus.ldSR);
  end

  // Stage p0: flag register and change pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_p0  <= 4'b0000;
      chg_p0 <= 1'b0;
    end else begin
      sr_p0  <= sr_next;
      chg_p0 <= (sr_next != sr_p0);
    end
  end

  assign bus.SR           = sr_p0;
  assign bus.flagsChanged = chg_p0;
  // Uses the registered flags only; a load in this cycle is not seen yet.
  assign bus.enSKP        = skip_eval(bus.inst, sr_p0);

endmodule

// File: doc/status_skip_unit.md
# status_skip_unit

Status-register and skip-condition block of the PUNEH datapath, directly upstream of the controller's `enSKP` input. It holds the four processor flags {Z, N, C, V}. It updates them under the controller's `ldSR` bit mask from one of three sources: ARU result, LGU result, or the SET immediate. It evaluates the condition of the SKP instruction in the instruction register and drives `enSKP` back to the controller in the same exec1 cycle.

## Interface
- `W`, 16, datapath width (AC, ARU/LGU result width)
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `inst`  in  16  current IR contents
- `ldSR`  in  4  per-flag load enables: bit3=Z, bit2=N, bit1=C, bit0=V
- `selSET_SR`  in  1  flag source = `inst[3:0]`
- `selARU_SR`  in  1  flag source = ARU result/carry/overflow
- `selLGU_SR`  in  1  flag source = LGU result
- `aruResult`  in  W  ARU output
- `aruCarry`  in  1  ARU carry-out of MSB
- `aruOverflow`  in  1  ARU signed overflow
- `lguResult`  in  W  LGU output
- `SR`  out  4  registered flags {Z,N,C,V}
- `enSKP`  out  1  skip condition true for SKP in IR (combinational from `SR`, `inst`)
- `flagsChanged`  out  1  registered pulse: at least one flag changed value on the previous edge

## Operation
- Flag register: 4 independent flops, SR[3]=Z, SR[2]=N, SR[1]=C, SR[0]=V.
- Source select, fixed priority: `selSET_SR` > `selARU_SR` > `selLGU_SR`. If none is asserted, the candidate is the current SR (hold), even with `ldSR`≠0.
- Candidate values:
  - SET: {Z,N,C,V} = `inst[3:0]`.
  - ARU: Z = (aruResult==0), N = aruResult[W-1], C = aruCarry, V = aruOverflow.
  - LGU: Z = (lguResult==0), N = lguResult[W-1], C = 0, V = 0.
- Per-bit load: SR[i] ← candidate[i] when ldSR[i]=1, else hold. Typical masks are 1111 for add, 1100 for logic ops and ACZ/ACN, and 1000 for MUL; the block treats every mask identically.
- Skip decode is active only when inst[15:12]=4'b1111 and inst[11:8]=4'b0101; otherwise `enSKP`=0.
  - Mask M = inst[7:4] selects which flags are tested. Value P = inst[3:0] gives the required polarity per flag.
  - enSKP = AND over i of (~M[i] | (SR[i] == P[i])).
  - M=0000 means an unconditional skip (`enSKP`=1).
- `enSKP` uses the registered SR only. A flag load in the same cycle does not affect it.
- `flagsChanged` ← (SR_next != SR) on each edge; cleared by reset.

## Timing
- Reset (`rst`=1 at a rising edge): SR=4'b0000, `flagsChanged`=0. `enSKP` then follows the decode with SR=0; for example, an SKP with M=0000 still gives 1.
- Reset has priority over any simultaneous load. Reset asserted mid-instruction discards the pending update.
- Load latency: flag values appear on `SR` one cycle after the cycle in which `ldSR`/select are asserted, i.e. from the fetch following the exec cycle.
- `enSKP` latency: zero cycles, combinational from IR and SR. It must be stable by the end of the SKP exec1 cycle; path = SR flops + 8-bit compare + 4-input AND.
- Back-to-back: a flag-setting instruction followed immediately by SKP sees the updated flags, because at least a fetch cycle lies between the two exec1 cycles.
- Multiple selects in one cycle: resolved by the priority above, with no error indication.
- `aruResult`/`lguResult` are sampled only when the corresponding select is active and `ldSR`≠0; X on unselected sources must not propagate.

## Test plan
- Reset: rst=1 for 1 edge with ldSR=1111, selARU_SR=1, aruResult=0 -> SR=0000, flagsChanged=0.
- ARU full load: ldSR=1111, selARU_SR=1, aruResult=16'h8000, aruCarry=1, aruOverflow=1 -> next cycle SR=0111 (Z=0,N=1,C=1,V=1), flagsChanged=1.
- LGU partial mask: SR=0111, ldSR=1100, selLGU_SR=1, lguResult=16'h0000 -> SR=1011 (C,V held); then MUL-style ldSR=1000, selARU_SR=1, aruResult=16'h0005 -> SR=0011.
- SET with priority: selSET_SR=selARU_SR=1, ldSR=1111, inst=16'hF6F5 -> SR=0101 (ARU ignored); repeat with ldSR=0000 -> SR unchanged, flagsChanged=0.
- Skip decode: SR=1000; inst=16'hF588 -> enSKP=1; inst=16'hF580 -> enSKP=0; inst=16'hF500 -> enSKP=1; inst=16'hF600 -> enSKP=0; inst=16'h0500 -> enSKP=0.
- Same-cycle load vs skip: SR=0000, inst=16'hF588, ldSR=1000, selSET_SR=1 with inst[3:0]=8 -> enSKP=0 in that cycle, SR=1000 and enSKP=1 in the next.
